fft_peak_detect: RTL and testbench



---
 rtl/fft_peak_pkg.sv | 29 ++
 rtl/fft_l1_mag.sv | 29 ++
 rtl/fft_peak_detect.sv | 176 +++++++++++++++++
 tb/tb_fft_peak_detect.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fft_peak_pkg.sv
// Shared types and helpers for the FFT peak detector: FSM state encoding and the
// L1 magnitude function used by the magnitude pipeline stage.
package fft_peak_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BIN_W_DEFAULT = 18;
  localparam int LAST_BIN      = 2**BIN_W_DEFAULT - 1;

  // Operands are sign-extended to 32 bits by the caller; 33 result bits hold
  // |-2**31| + |-2**31| without overflow, so no saturation is ever needed.
  function automatic logic [32:0] l1_mag(input logic signed [31:0] re,
                                         input logic signed [31:0] im);
    logic signed [32:0] re_x;
    logic signed [32:0] im_x;
    logic        [32:0] abs_re;
    logic        [32:0] abs_im;
    re_x   = 33'(re);
    im_x   = 33'(im);
    abs_re = re_x[32] ? 33'(-re_x) : 33'(re_x);
    abs_im = im_x[32] ? 33'(-im_x) : 33'(im_x);
    return abs_re + abs_im;
  endfunction

endpackage

// File: rtl/fft_l1_mag.sv
// Pipeline stage 1 of the peak detector: registered |re| + |im|, one cycle latency.
// Supports DATA_W up to 32.
module fft_l1_mag
  import fft_peak_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] re,
  input  logic signed [DATA_W-1:0] im,
  output logic        [DATA_W:0]   mag
);

  logic [DATA_W:0] mag_d;
  logic [DATA_W:0] mag_q;

  always_comb begin
    mag_d = (DATA_W+1)'(l1_mag(32'(re), 32'(im)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mag_q <= '0;
    else     mag_q <= mag_d;
  end

  assign mag = mag_q;

endmodule

// File: rtl/fft_peak_detect.sv
// Per-frame peak search over the FFT source stream with sop/eop framing checks.
// Optional macro FFT_PEAK_SKIP_DC_EN excludes bin 0 from the search (bin 1 seeds it).
module fft_peak_detect
  import fft_peak_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int BIN_W  = 18
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     source_valid,
  input  logic                     source_sop,
  input  logic                     source_eop,
  input  logic signed [DATA_W-1:0] source_real,
  input  logic signed [DATA_W-1:0] source_imag,
  output logic                     peak_valid,
  output logic        [BIN_W-1:0]  peak_bin,
  output logic        [DATA_W:0]   peak_mag,
  output logic                     frame_err
);

  localparam logic [BIN_W-1:0] LAST_IDX = {BIN_W{1'b1}};
`ifdef FFT_PEAK_SKIP_DC_EN
  localparam logic [BIN_W-1:0] FIRST_BIN = BIN_W'(1);
  localparam logic             SKIP_DC   = 1'b1;
`else
  localparam logic [BIN_W-1:0] FIRST_BIN = '0;
  localparam logic             SKIP_DC   = 1'b0;
`endif

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   cnt_q, cnt_d;
  logic               frame_err_q, frame_err_d;

  logic               acc;
  logic [BIN_W-1:0]   acc_bin;
  logic               acc_last;

  logic               s1_valid_q, s1_valid_d;
  logic               s1_first_q, s1_first_d;
  logic               s1_last_q, s1_last_d;
  logic [BIN_W-1:0]   s1_bin_q, s1_bin_d;
  logic [DATA_W:0]    s1_mag;

  logic [DATA_W:0]    max_mag_q, max_mag_d;
  logic [BIN_W-1:0]   max_bin_q, max_bin_d;
  logic               s2_last_q, s2_last_d;

  logic               peak_valid_q, peak_valid_d;
  logic [BIN_W-1:0]   peak_bin_q, peak_bin_d;
  logic [DATA_W:0]    peak_mag_q, peak_mag_d;

  fft_l1_mag #(.DATA_W(DATA_W)) u_mag (
    .clk (clk),
    .rst (rst),
    .re  (source_real),
    .im  (source_imag),
    .mag (s1_mag)
  );

  // Framing FSM: decides which beats enter the pipeline and flags violations.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_err_d = 1'b0;
    acc         = 1'b0;
    acc_bin     = cnt_q;
    acc_last    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (source_valid && source_sop) begin
          acc         = 1'b1;
          acc_bin     = '0;
          cnt_d       = BIN_W'(1);
          state_d     = ACCUM;
          frame_err_d = source_eop;
        end else if (state_q == DONE && s2_last_q) begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (source_valid) begin
          if (source_sop) begin
            frame_err_d = 1'b1;
            acc         = 1'b1;
            acc_bin     = '0;
            cnt_d       = BIN_W'(1);
          end else if (source_eop) begin
            cnt_d = '0;
            if (cnt_q == LAST_IDX) begin
              acc      = 1'b1;
              acc_last = 1'b1;
              state_d  = DONE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = IDLE;
            end
          end else if (cnt_q == LAST_IDX) begin
            frame_err_d = 1'b1;
            cnt_d       = '0;
            state_d     = IDLE;
          end else begin
            acc   = 1'b1;
            cnt_d = cnt_q + BIN_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Tags travel beside the magnitude so stage 2 sees bin, seed and end-of-frame together.
  always_comb begin
    s1_valid_d = acc && !(SKIP_DC && acc_bin == '0);
    s1_first_d = acc && (acc_bin == FIRST_BIN);
    s1_last_d  = acc_last;
    s1_bin_d   = acc_bin;

    max_mag_d = max_mag_q;
    max_bin_d = max_bin_q;
    if (s1_valid_q && (s1_first_q || s1_mag > max_mag_q)) begin
      max_mag_d = s1_mag;
      max_bin_d = s1_bin_q;
    end
    s2_last_d = s1_last_q;

    peak_valid_d = s2_last_q;
    peak_bin_d   = peak_bin_q;
    peak_mag_d   = peak_mag_q;
    if (s2_last_q) begin
      peak_bin_d = max_bin_q;
      peak_mag_d = max_mag_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      frame_err_q  <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_first_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_bin_q     <= '0;
      max_mag_q    <= '0;
      max_bin_q    <= '0;
      s2_last_q    <= 1'b0;
      peak_valid_q <= 1'b0;
      peak_bin_q   <= '0;
      peak_mag_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      frame_err_q  <= frame_err_d;
      s1_valid_q   <= s1_valid_d;
      s1_first_q   <= s1_first_d;
      s1_last_q    <= s1_last_d;
      s1_bin_q     <= s1_bin_d;
      max_mag_q    <= max_mag_d;
      max_bin_q    <= max_bin_d;
      s2_last_q    <= s2_last_d;
      peak_valid_q <= peak_valid_d;
      peak_bin_q   <= peak_bin_d;
      peak_mag_q   <= peak_mag_d;
    end
  end

  assign peak_valid = peak_valid_q;
  assign peak_bin   = peak_bin_q;
  assign peak_mag   = peak_mag_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_fft_peak_detect.sv
// Scoreboard bench for fft_peak_detect at BIN_W=3, DATA_W=8; expected events are
// queued as stimulus is driven and popped when peak_valid or frame_err fires.
module tb_fft_peak_detect;

  localparam int DATA_W = 8;
  localparam int BIN_W  = 3;
  localparam int NBINS  = 2**BIN_W;
`ifdef FFT_PEAK_SKIP_DC_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif

  typedef struct {
    bit is_err;
    int cyc;
    int bin;
    int mag;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     source_valid = 1'b0;
  logic                     source_sop = 1'b0;
  logic                     source_eop = 1'b0;
  logic signed [DATA_W-1:0] source_real = '0;
  logic signed [DATA_W-1:0] source_imag = '0;
  logic                     peak_valid;
  logic        [BIN_W-1:0]  peak_bin;
  logic        [DATA_W:0]   peak_mag;
  logic                     frame_err;

  int   n_compared   = 0;
  int   n_mismatched = 0;
  int   cyc          = 0;
  exp_t sb_q[$];
  int   fr_re[NBINS];
  int   fr_im[NBINS];
  int   good_bin = 0;
  int   good_mag = 0;

  fft_peak_detect #(.DATA_W(DATA_W), .BIN_W(BIN_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .source_valid (source_valid),
    .source_sop   (source_sop),
    .source_eop   (source_eop),
    .source_real  (source_real),
    .source_imag  (source_imag),
    .peak_valid   (peak_valid),
    .peak_bin     (peak_bin),
    .peak_mag     (peak_mag),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic modelPeak(output int bin, output int mag);
    int m;
    bin = FIRST;
    mag = iabs(fr_re[FIRST]) + iabs(fr_im[FIRST]);
    for (int b = FIRST + 1; b < NBINS; b++) begin
      m = iabs(fr_re[b]) + iabs(fr_im[b]);
      if (m > mag) begin
        mag = m;
        bin = b;
      end
    end
  endtask

  // Drives one cycle of input; edge returns the clock edge that samples it.
  task automatic applyStimulus(input logic v, input logic sop, input logic eop,
                               input int re, input int im, output int edge_no);
    @(negedge clk);
    source_valid = v;
    source_sop   = sop;
    source_eop   = eop;
    source_real  = DATA_W'(re);
    source_imag  = DATA_W'(im);
    edge_no      = cyc + 1;
  endtask

  task automatic idle(input int n);
    int e;
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, e);
  endtask

  task automatic pushErr(input int edge_no);
    sb_q.push_back('{is_err: 1'b1, cyc: edge_no, bin: 0, mag: 0});
  endtask

  task automatic driveFrame(input bit gaps, input bit sop_is_err);
    int e;
    int bn;
    int mg;
    for (int b = 0; b < NBINS; b++) begin
      if (gaps) idle((b == 3) ? 2 : int'($urandom_range(0, 2)));
      applyStimulus(1'b1, b == 0, b == NBINS - 1, fr_re[b], fr_im[b], e);
      if (b == 0 && sop_is_err) pushErr(e);
    end
    modelPeak(bn, mg);
    sb_q.push_back('{is_err: 1'b0, cyc: e + 2, bin: bn, mag: mg});
    good_bin = bn;
    good_mag = mg;
  endtask

  task automatic fillFrame(input int re, input int im);
    for (int b = 0; b < NBINS; b++) begin
      fr_re[b] = re;
      fr_im[b] = im;
    end
  endtask

  task automatic handleEvent(input bit is_err);
    exp_t ex;
    if (sb_q.size() == 0) begin
      checkOutput(is_err ? "unexpected_frame_err" : "unexpected_peak_valid", 1, 0);
    end else begin
      ex = sb_q.pop_front();
      checkOutput("event_kind", 32'(is_err), 32'(ex.is_err));
      checkOutput("event_cycle", cyc, ex.cyc);
      if (!is_err) begin
        checkOutput("peak_bin", 32'(peak_bin), ex.bin);
        checkOutput("peak_mag", 32'(peak_mag), ex.mag);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (peak_valid) handleEvent(1'b0);
      if (frame_err)  handleEvent(1'b1);
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_peak_valid"}, 32'(peak_valid), 0);
    checkOutput({tag, "_frame_err"},  32'(frame_err),  0);
    checkOutput({tag, "_peak_bin"},   32'(peak_bin),   0);
    checkOutput({tag, "_peak_mag"},   32'(peak_mag),   0);
  endtask

  initial begin
    int e;

    repeat (2) @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b0;
    idle(2);

    // Single strong bin among small ones
    fillFrame(1, 1);
    fr_re[5] = -100; fr_im[5] = 20;
    driveFrame(1'b0, 1'b0);
    idle(4);

    // Equal magnitudes: earliest bin wins
    fillFrame(0, 0);
    fr_re[2] = 50; fr_im[2] = -50;
    fr_re[6] = 50; fr_im[6] = -50;
    driveFrame(1'b0, 1'b0);
    idle(4);

    // Early eop on bin 4
    for (int b = 0; b <= 4; b++) begin
      applyStimulus(1'b1, b == 0, b == 4, 120, 120, e);
      if (b == 4) pushErr(e);
    end
    idle(5);
    checkOutput("hold_bin", 32'(peak_bin), good_bin);
    checkOutput("hold_mag", 32'(peak_mag), good_mag);

    // sop at bin 3 restarts the frame, then a zero-gap frame with extremes at DC
    for (int b = 0; b < 3; b++) applyStimulus(1'b1, b == 0, 1'b0, 90, 90, e);
    fillFrame(2, 3);
    fr_re[7] = 30; fr_im[7] = -40;
    driveFrame(1'b0, 1'b1);
    fillFrame(0, 0);
    fr_re[0] = -128; fr_im[0] = -128;
    fr_re[3] = 10;
    driveFrame(1'b0, 1'b0);
    idle(5);

    // Reset in the middle of a frame
    for (int b = 0; b < 4; b++) applyStimulus(1'b1, b == 0, 1'b0, 100, 0, e);
    @(negedge clk);
    source_valid = 1'b1;
    source_sop   = 1'b0;
    source_real  = DATA_W'(100);
    rst          = 1'b1;
    #1;
    checkResetOutputs("midrst");
    idle(2);
    rst = 1'b0;
    idle(2);

    // Good frame with valid gaps
    fillFrame(3, -4);
    fr_re[6] = -7; fr_im[6] = 90;
    driveFrame(1'b1, 1'b0);
    idle(6);

    checkOutput("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
